uart_rx_ctrl: RTL and testbench

UART receive controller. It oversamples the serial line, sequences the frame (start, 8 data bits LSB-first, optional parity, stop) and performs the parity and stop-bit checks. It sits between the RX pin and the byte consumer: it emits one validated byte per frame, plus error flags.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DATA_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rxState_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX pin; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '1;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled frame sequencing (start, 8 data LSB-first, optional parity, stop)
// with parity and framing checks; one result pulse per frame.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_in,
    input  logic              parity_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_error,
    output logic              framing_error,
    output logic              busy
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic              w_rxS;
    logic              w_bitTick;
    logic              w_frameDone;
    logic              w_parErr;
    rxState_t          r_state;
    rxState_t          w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bitIdx;
    logic [DATA_W-1:0] r_shift;
    logic              r_parQ;
    logic              r_pbit;
    logic [DATA_W-1:0] r_rxData;
    logic              r_rxValid;
    logic              r_parityError;
    logic              r_framingError;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_async (RX_in),
        .o_sync  (w_rxS)
    );

    assign w_bitTick = (r_cnt == BIT_M1);
    assign w_parErr  = r_parQ & (r_pbit != ^r_shift);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_frameDone = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxS) w_nextState = START;
            end
            START: begin
                if (r_cnt == HALF_M1) w_nextState = w_rxS ? IDLE : DATA;
            end
            DATA: begin
                if (w_bitTick && (r_bitIdx == 3'd7)) w_nextState = r_parQ ? PARITY : STOP;
            end
            PARITY: begin
                if (w_bitTick) w_nextState = STOP;
            end
            STOP: begin
                // Leaving at the stop midpoint leaves half a bit of slack for the next start edge
                if (w_bitTick) begin
                    w_frameDone = 1'b1;
                    w_nextState = w_rxS ? IDLE : BREAK_WAIT;
                end
            end
            BREAK_WAIT: begin
                if (w_rxS) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt          <= '0;
            r_bitIdx       <= 3'd0;
            r_shift        <= '0;
            r_parQ         <= 1'b0;
            r_pbit         <= 1'b0;
            r_rxData       <= '0;
            r_rxValid      <= 1'b0;
            r_parityError  <= 1'b0;
            r_framingError <= 1'b0;
        end else begin
            // Every state change restarts the bit-period counter
            if (r_state == IDLE || r_state == BREAK_WAIT || w_nextState != r_state) begin
                r_cnt <= '0;
            end else if (w_bitTick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == IDLE && !w_rxS) begin
                r_parQ <= parity_en;
            end

            if (r_state == START && w_nextState == DATA) begin
                r_bitIdx <= 3'd0;
            end

            if (r_state == DATA && w_bitTick) begin
                r_shift[r_bitIdx] <= w_rxS;
                r_bitIdx          <= r_bitIdx + 3'd1;
            end

            if (r_state == PARITY && w_bitTick) begin
                r_pbit <= w_rxS;
            end

            r_rxValid <= w_frameDone;
            if (w_frameDone) begin
                r_rxData       <= w_parErr ? '0 : r_shift;
                r_parityError  <= w_parErr;
                r_framingError <= ~w_rxS;
            end
        end
    end

    assign rx_data       = r_rxData;
    assign rx_valid      = r_rxValid;
    assign parity_error  = r_parityError;
    assign framing_error = r_framingError;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of directed frames, corner sequences, random frames.
module tb_uart_rx_ctrl;

    localparam int N    = 16;
    localparam int SYNC = 2;

    typedef struct {
        logic [7:0] data;
        bit         parEn;
        bit         pbit;
        bit         stopBit;
        int         holdLow;
        logic [7:0] expData;
        bit         expPerr;
        bit         expFerr;
        bit         expBusy;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } rxEvent_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       rxIn;
    logic       parityEn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       parityError;
    logic       framingError;
    logic       busy;

    int         edgeCount   = 0;
    int         assertCount = 0;
    int         failCount   = 0;
    rxEvent_t   evQ[$];
    vec_t       vecs[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT(N),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK          (clock),
        .RST          (reset),
        .RX_in        (rxIn),
        .parity_en    (parityEn),
        .rx_data      (rxData),
        .rx_valid     (rxValid),
        .parity_error (parityError),
        .framing_error(framingError),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Cycle index used by every timing expectation
    always @(posedge clock) edgeCount <= edgeCount + 1;

    // Capture every result pulse with its cycle and the outputs that accompany it
    always @(negedge clock) begin
        if (rxValid) begin
            evQ.push_back('{cyc: edgeCount, data: rxData, perr: parityError,
                            ferr: framingError, busy: busy});
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitCycle(input int target);
        do @(negedge clock); while (edgeCount < target);
    endtask

    task automatic idleLine(input int cycles);
        rxIn = 1'b1;
        repeat (cycles) tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one frame on the pin, starting in the current cycle; pinCycle is where the start bit begins
    task automatic applyStimulus(input logic [7:0] data, input bit parEn, input bit pbit,
                                 input bit stopBit, input int holdLow, output int pinCycle);
        pinCycle = edgeCount;
        parityEn = parEn;
        rxIn     = 1'b0;
        repeat (N) tick();
        parityEn = ~parEn;
        for (int k = 0; k < 8; k++) begin
            rxIn = data[k];
            repeat (N) tick();
        end
        if (parEn) begin
            rxIn = pbit;
            repeat (N) tick();
        end
        rxIn = stopBit;
        repeat (N) tick();
        if (!stopBit) repeat (holdLow) tick();
    endtask

    task automatic checkEvent(input string name, input int expCycle, input logic [7:0] expData,
                              input bit expPerr, input bit expFerr, input bit expBusy);
        rxEvent_t ev;
        if (evQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s_present: got no rx_valid, expected one at cycle %0d", name, expCycle);
        end else begin
            ev = evQ.pop_front();
            checkOutput({name, "_cycle"}, ev.cyc, expCycle);
            checkOutput({name, "_data"},  {24'd0, ev.data}, {24'd0, expData});
            checkOutput({name, "_perr"},  {31'd0, ev.perr}, {31'd0, expPerr});
            checkOutput({name, "_ferr"},  {31'd0, ev.ferr}, {31'd0, expFerr});
            checkOutput({name, "_busy"},  {31'd0, ev.busy}, {31'd0, expBusy});
        end
    endtask

    // Timing model: pin-to-t0 latency, half a bit to the start centre, then whole bits to the stop centre
    function automatic int validCycle(input int pinCycle, input bit parEn);
        return pinCycle + SYNC + N / 2 + (parEn ? 10 * N : 9 * N) + 1;
    endfunction

    initial begin
        int         pc;
        int         pc2;
        int         rise;
        int         cur;
        int         gap;
        logic [7:0] d;
        logic [7:0] rData;
        bit         rPar;
        bit         rPbit;
        bit         rStop;
        int         rHold;
        bit         ePerr;

        vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b1, 0,  8'h3C, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b1, 1'b1, 1'b1, 0,  8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 0,  8'h81, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h7F, 1'b1, 1'b0, 1'b0, 20, 8'h00, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 0,  8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 40, 8'h55, 1'b0, 1'b1, 1'b1});

        reset    = 1'b1;
        rxIn     = 1'b1;
        parityEn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_busy",  {31'd0, busy},         32'd0);
        checkOutput("reset_valid", {31'd0, rxValid},      32'd0);
        checkOutput("reset_data",  {24'd0, rxData},       32'd0);
        checkOutput("reset_perr",  {31'd0, parityError},  32'd0);
        checkOutput("reset_ferr",  {31'd0, framingError}, 32'd0);
        tick();
        reset = 1'b0;
        idleLine(N);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].data, vecs[i].parEn, vecs[i].pbit, vecs[i].stopBit,
                          vecs[i].holdLow, pc);
            checkEvent($sformatf("vec%0d", i), validCycle(pc, vecs[i].parEn), vecs[i].expData,
                       vecs[i].expPerr, vecs[i].expFerr, vecs[i].expBusy);
            if (!vecs[i].stopBit) begin
                checkOutput($sformatf("vec%0d_break_busy", i), {31'd0, busy}, 32'd1);
                rxIn = 1'b1;
                rise = edgeCount;
                waitCycle(rise + SYNC);
                checkOutput($sformatf("vec%0d_break_hold", i), {31'd0, busy}, 32'd1);
                waitCycle(rise + SYNC + 1);
                checkOutput($sformatf("vec%0d_break_exit", i), {31'd0, busy}, 32'd0);
                tick();
            end
            idleLine(2 * N);
            checkOutput($sformatf("vec%0d_extra", i), evQ.size(), 32'd0);
        end

        // Reset in the middle of data bit 4 discards the frame
        d        = 8'h81;
        parityEn = 1'b0;
        rxIn     = 1'b0;
        repeat (N) tick();
        for (int k = 0; k < 4; k++) begin
            rxIn = d[k];
            repeat (N) tick();
        end
        rxIn = d[4];
        repeat (N / 2) tick();
        reset = 1'b1;
        rxIn  = 1'b1;
        cur   = edgeCount;
        waitCycle(cur + 1);
        checkOutput("rst_mid_busy",  {31'd0, busy},         32'd0);
        checkOutput("rst_mid_valid", {31'd0, rxValid},      32'd0);
        checkOutput("rst_mid_data",  {24'd0, rxData},       32'd0);
        checkOutput("rst_mid_perr",  {31'd0, parityError},  32'd0);
        checkOutput("rst_mid_ferr",  {31'd0, framingError}, 32'd0);
        tick();
        reset = 1'b0;
        idleLine(2 * N);
        checkOutput("rst_mid_extra", evQ.size(), 32'd0);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b1, 0, pc);
        checkEvent("rst_after", validCycle(pc, 1'b1), 8'h81, 1'b0, 1'b0, 1'b0);
        idleLine(N);

        // Five-cycle low glitch is rejected at the start-bit centre
        pc   = edgeCount;
        rxIn = 1'b0;
        waitCycle(pc + SYNC);
        checkOutput("glitch_t0_busy", {31'd0, busy}, 32'd0);
        waitCycle(pc + SYNC + 1);
        checkOutput("glitch_t1_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        rxIn = 1'b1;
        waitCycle(pc + SYNC + N / 2);
        checkOutput("glitch_t8_busy", {31'd0, busy}, 32'd1);
        waitCycle(pc + SYNC + N / 2 + 1);
        checkOutput("glitch_t9_busy", {31'd0, busy}, 32'd0);
        tick();
        idleLine(2 * N);
        checkOutput("glitch_no_valid", evQ.size(), 32'd0);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1, 0, pc);
        checkEvent("glitch_next", validCycle(pc, 1'b0), 8'hC3, 1'b0, 1'b0, 1'b0);
        idleLine(N);

        // Back-to-back frames with the second start bit right at the stop boundary
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 0, pc);
        applyStimulus(8'hFE, 1'b0, 1'b0, 1'b1, 0, pc2);
        checkEvent("b2b_first",  validCycle(pc,  1'b0), 8'h01, 1'b0, 1'b0, 1'b0);
        checkEvent("b2b_second", validCycle(pc2, 1'b0), 8'hFE, 1'b0, 1'b0, 1'b0);
        idleLine(N);
        checkOutput("b2b_extra", evQ.size(), 32'd0);

        for (int r = 0; r < 24; r++) begin
            rData = 8'($urandom_range(0, 255));
            rPar  = 1'($urandom_range(0, 1));
            rPbit = 1'($urandom_range(0, 1));
            rStop = ($urandom_range(0, 3) != 0);
            rHold = $urandom_range(0, 30);
            gap   = rStop ? $urandom_range(0, 20) : $urandom_range(3, 20);
            ePerr = rPar && (rPbit != ^rData);
            applyStimulus(rData, rPar, rPbit, rStop, rHold, pc);
            checkEvent($sformatf("rand%0d", r), validCycle(pc, rPar), ePerr ? 8'h00 : rData,
                       ePerr, !rStop, !rStop);
            idleLine(gap);
        end
        idleLine(2 * N);
        checkOutput("rand_extra", evQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
